// File: rtl/serial_port_pkg.sv
// Shared definitions for the serial_port UART peripheral.
// Register addresses, STATUS bit positions and engine state encoding.
// No logic of its own beyond a small divisor clamp helper.
package serial_port_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;

  localparam int ST_RX_AVAIL    = 0;
  localparam int ST_TX_NOT_FULL = 1;
  localparam int ST_RX_OVERRUN  = 2;
  localparam int ST_TX_IDLE     = 3;
  localparam int ST_FRAMING_ERR = 4;
  localparam int ST_TX_OVERFLOW = 5;

  typedef enum logic [1:0] {
    ENG_IDLE  = 2'd0,
    ENG_START = 2'd1,
    ENG_DATA  = 2'd2,
    ENG_STOP  = 2'd3
  } eng_state_t;

  // A divisor below 2 would make the half-bit RX count zero, so clamp it.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

endpackage

// File: rtl/serial_fifo.sv
// Small synchronous FIFO holding bytes for the UART TX and RX paths.
// Head is valid combinationally the cycle after a push; push/pop take effect at the edge.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module serial_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/serial_port.sv
// Bus-attached 8N1 UART with TX/RX FIFOs, sticky status flags and a baud divisor.
// Register reads are combinational; writes and read side effects land on the ending clock edge.
// No bus stall: TX writes to a full FIFO are dropped (tx_overflow), RX bytes into a full FIFO are dropped (rx_overrun).
module serial_port
  import serial_port_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_in,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  input  logic        MI,
  input  logic        DI,
  input  logic        DO,
  output logic        txd,
  input  logic        rxd
);

  logic [1:0]  addr;
  logic [15:0] div;
  logic [15:0] status;
  logic        stat_rd;
  logic        rx_overrun, framing_err, tx_overflow;

  logic        tx_push, tx_pop, tx_full, tx_empty, tx_idle;
  logic [7:0]  tx_head;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head;

  eng_state_t  tx_state, tx_nxt;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_load, tx_shift;

  eng_state_t  rx_state, rx_nxt;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_load, rx_load_half, rx_shift, fr_set;
  logic        rx_s1, rx_s2, rx_s3, rx_fall;

  assign bus_oe  = DO;
  assign stat_rd = DO && (addr == ADDR_STATUS);
  assign tx_push = DI && (addr == ADDR_DATA);
  assign rx_pop  = DO && (addr == ADDR_DATA);
  assign tx_idle = tx_empty && (tx_state == ENG_IDLE);
  assign rx_fall = rx_s3 && !rx_s2;

  serial_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(reset), .push(tx_push), .pop(tx_pop), .din(bus_in[7:0]),
    .full(tx_full), .empty(tx_empty), .head(tx_head)
  );

  serial_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(reset), .push(rx_push), .pop(rx_pop), .din(rx_sh),
    .full(rx_full), .empty(rx_empty), .head(rx_head)
  );

  // Address latch and divisor register; an access in the MI cycle still uses the old address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= ADDR_DATA;
      div  <= DIV_RESET;
    end else begin
      if (MI) addr <= bus_in[1:0];
      if (DI && (addr == ADDR_DIV)) div <= clamp_div(bus_in);
    end
  end

  // Sticky flags: a new event wins over a simultaneous STATUS read clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_overrun  <= 1'b0;
      framing_err <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (rx_push && rx_full && !rx_pop)      rx_overrun <= 1'b1;
      else if (stat_rd)                       rx_overrun <= 1'b0;
      if (fr_set)                             framing_err <= 1'b1;
      else if (stat_rd)                       framing_err <= 1'b0;
      if (tx_push && tx_full && !tx_pop)      tx_overflow <= 1'b1;
      else if (stat_rd)                       tx_overflow <= 1'b0;
    end
  end

  // Status word and read mux; the bus is driven with zero whenever DO is low.
  always_comb begin
    status                 = '0;
    status[ST_RX_AVAIL]    = !rx_empty;
    status[ST_TX_NOT_FULL] = !tx_full;
    status[ST_RX_OVERRUN]  = rx_overrun;
    status[ST_TX_IDLE]     = tx_idle;
    status[ST_FRAMING_ERR] = framing_err;
    status[ST_TX_OVERFLOW] = tx_overflow;
    bus_out = '0;
    if (DO) begin
      case (addr)
        ADDR_DATA:   bus_out = rx_empty ? 16'h0000 : {8'h00, rx_head};
        ADDR_STATUS: bus_out = status;
        ADDR_DIV:    bus_out = div;
        default:     bus_out = '0;
      endcase
    end
  end

  // TX engine registers; each bit reloads from div so a divisor change applies from the next bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= ENG_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= 8'hFF;
    end else begin
      tx_state <= tx_nxt;
      if (tx_load)            tx_cnt <= div - 16'd1;
      else if (tx_cnt != '0)  tx_cnt <= tx_cnt - 16'd1;
      if (tx_pop) begin
        tx_sh  <= tx_head;
        tx_bit <= '0;
      end else if (tx_shift) begin
        tx_sh  <= {1'b1, tx_sh[7:1]};
        tx_bit <= tx_bit + 3'd1;
      end
    end
  end

  // TX next state and line value; STOP chains straight into START when more data waits.
  always_comb begin
    tx_nxt   = tx_state;
    tx_pop   = 1'b0;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    txd      = 1'b1;
    case (tx_state)
      ENG_IDLE: begin
        if (!tx_empty) begin
          tx_nxt  = ENG_START;
          tx_pop  = 1'b1;
          tx_load = 1'b1;
        end
      end
      ENG_START: begin
        txd = 1'b0;
        if (tx_cnt == '0) begin
          tx_nxt  = ENG_DATA;
          tx_load = 1'b1;
        end
      end
      ENG_DATA: begin
        txd = tx_sh[0];
        if (tx_cnt == '0) begin
          tx_load  = 1'b1;
          tx_shift = 1'b1;
          if (tx_bit == 3'd7) tx_nxt = ENG_STOP;
        end
      end
      ENG_STOP: begin
        if (tx_cnt == '0) begin
          if (!tx_empty) begin
            tx_nxt  = ENG_START;
            tx_pop  = 1'b1;
            tx_load = 1'b1;
          end else begin
            tx_nxt = ENG_IDLE;
          end
        end
      end
      default: tx_nxt = ENG_IDLE;
    endcase
  end

  // Two-flop synchroniser for rxd plus one more stage for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // RX engine registers; the first reload is half a bit so later samples land mid-bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= ENG_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_state <= rx_nxt;
      if (rx_load_half)       rx_cnt <= (div >> 1) - 16'd1;
      else if (rx_load)       rx_cnt <= div - 16'd1;
      else if (rx_cnt != '0)  rx_cnt <= rx_cnt - 16'd1;
      if (rx_load_half) begin
        rx_bit <= '0;
      end else if (rx_shift) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
    end
  end

  // RX next state: glitch rejection at mid start bit, stop-bit check decides push or framing error.
  always_comb begin
    rx_nxt       = rx_state;
    rx_load      = 1'b0;
    rx_load_half = 1'b0;
    rx_shift     = 1'b0;
    rx_push      = 1'b0;
    fr_set       = 1'b0;
    case (rx_state)
      ENG_IDLE: begin
        if (rx_fall) begin
          rx_nxt       = ENG_START;
          rx_load_half = 1'b1;
        end
      end
      ENG_START: begin
        if (rx_cnt == '0) begin
          if (rx_s2) begin
            rx_nxt = ENG_IDLE;
          end else begin
            rx_nxt  = ENG_DATA;
            rx_load = 1'b1;
          end
        end
      end
      ENG_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift = 1'b1;
          rx_load  = 1'b1;
          if (rx_bit == 3'd7) rx_nxt = ENG_STOP;
        end
      end
      ENG_STOP: begin
        if (rx_cnt == '0) begin
          rx_nxt = ENG_IDLE;
          if (rx_s2) rx_push = 1'b1;
          else       fr_set  = 1'b1;
        end
      end
      default: rx_nxt = ENG_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_port.sv
module tb_serial_port;
  import serial_port_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bus_in = '0;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        MI = 1'b0, DI = 1'b0, DO = 1'b0;
  logic        txd;
  logic        rxd = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_div   = 104;
  logic mon_en = 1'b1;
  logic last_oe;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[15];

  serial_port #(.FIFO_DEPTH(8), .DIV_RESET(16'd104)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .MI(MI), .DI(DI), .DO(DO), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // One bus cycle; read data sampled mid-cycle, strobes dropped after the edge.
  task automatic cyc(input logic mi, input logic di, input logic dox, input logic [15:0] b,
                     output logic [15:0] rd);
    @(negedge clk);
    MI = mi; DI = di; DO = dox; bus_in = b;
    #1 rd = bus_out;
    last_oe = bus_oe;
    @(posedge clk);
    #1 MI = 1'b0; DI = 1'b0; DO = 1'b0; bus_in = '0;
  endtask

  task automatic set_addr(input logic [1:0] a);
    logic [15:0] v;
    cyc(1'b1, 1'b0, 1'b0, {14'd0, a}, v);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    logic [15:0] v;
    set_addr(a);
    cyc(1'b0, 1'b1, 1'b0, d, v);
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] v);
    set_addr(a);
    cyc(1'b0, 1'b0, 1'b1, 16'h0, v);
  endtask

  task automatic rd_data_chk(input string name);
    logic [15:0] v;
    logic [15:0] e;
    cyc(1'b0, 1'b0, 1'b1, 16'h0, v);
    e = (exp_rx.size() != 0) ? {8'h00, exp_rx.pop_front()} : 16'h0000;
    check(name, v, e);
  endtask

  task automatic wait_tx_idle(input string name);
    logic [15:0] v;
    bit ok;
    ok = 0;
    set_addr(ADDR_STATUS);
    for (int i = 0; i < 3000; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 16'h0, v);
      if (v[ST_TX_IDLE]) begin
        ok = 1;
        break;
      end
    end
    check(name, {15'd0, ok}, 16'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk);
    rxd = v;
    repeat (tb_div - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(b[k]);
    drive_bit(stopb);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  // Follows one TX frame cycle by cycle from its first low sample and scores the byte.
  task automatic tx_frame();
    logic [7:0] b;
    logic v;
    logic bad;
    bad = 1'b0;
    b = '0;
    for (int c = 1; c < tb_div; c++) begin
      @(negedge clk);
      if (!mon_en) return;
      if (txd !== 1'b0) bad = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!mon_en) return;
      v = txd;
      b[k] = v;
      for (int c = 1; c < tb_div; c++) begin
        @(negedge clk);
        if (!mon_en) return;
        if (txd !== v) bad = 1'b1;
      end
    end
    for (int c = 0; c < tb_div; c++) begin
      @(negedge clk);
      if (!mon_en) return;
      if (txd !== 1'b1) bad = 1'b1;
    end
    check("tx_bit_timing", {15'd0, bad}, 16'd0);
    if (exp_tx.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL tx_unexpected_byte: got 0x%02h expected none", b);
    end else begin
      check("tx_byte", {8'h00, b}, {8'h00, exp_tx.pop_front()});
    end
  endtask

  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (mon_en && !reset && txd === 1'b0) tx_frame();
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] v;
    logic bad;

    vt[0]  = '{ADDR_STATUS, 1'b0, 16'h0000, 16'h000A};
    vt[1]  = '{ADDR_DATA,   1'b0, 16'h0000, 16'h0000};
    vt[2]  = '{2'd3,        1'b0, 16'h0000, 16'h0000};
    vt[3]  = '{2'd3,        1'b1, 16'hFFFF, 16'h0000};
    vt[4]  = '{2'd3,        1'b0, 16'h0000, 16'h0000};
    vt[5]  = '{ADDR_DIV,    1'b0, 16'h0000, 16'h0068};
    vt[6]  = '{ADDR_DIV,    1'b1, 16'h0000, 16'h0000};
    vt[7]  = '{ADDR_DIV,    1'b0, 16'h0000, 16'h0002};
    vt[8]  = '{ADDR_DIV,    1'b1, 16'h0001, 16'h0000};
    vt[9]  = '{ADDR_DIV,    1'b0, 16'h0000, 16'h0002};
    vt[10] = '{ADDR_DIV,    1'b1, 16'h1234, 16'h0000};
    vt[11] = '{ADDR_DIV,    1'b0, 16'h0000, 16'h1234};
    vt[12] = '{ADDR_DIV,    1'b1, 16'h0004, 16'h0000};
    vt[13] = '{ADDR_DIV,    1'b0, 16'h0000, 16'h0004};
    vt[14] = '{ADDR_STATUS, 1'b0, 16'h0000, 16'h000A};

    // Reset state
    #1;
    check("reset_txd", {15'd0, txd}, 16'd1);
    check("reset_bus_out", bus_out, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Register access table
    for (int i = 0; i < 15; i++) begin
      set_addr(vt[i].addr);
      if (vt[i].wr) begin
        cyc(1'b0, 1'b1, 1'b0, vt[i].wdata, v);
      end else begin
        cyc(1'b0, 1'b0, 1'b1, 16'h0, v);
        check($sformatf("vec%0d_read", i), v, vt[i].exp);
        check($sformatf("vec%0d_oe", i), {15'd0, last_oe}, 16'd1);
      end
    end
    tb_div = 4;

    // bus_out idle when DO is low; MI with DO reads the old address
    cyc(1'b1, 1'b0, 1'b0, 16'd2, v);
    check("bus_out_no_do", v, 16'h0000);
    check("oe_no_do", {15'd0, last_oe}, 16'd0);
    set_addr(ADDR_STATUS);
    cyc(1'b1, 1'b0, 1'b1, 16'd2, v);
    check("mi_do_old_addr", v, 16'h000A);
    cyc(1'b0, 1'b0, 1'b1, 16'h0, v);
    check("mi_do_new_addr", v, 16'h0004);

    // Single TX byte
    exp_tx.push_back(8'hA5);
    wr(ADDR_DATA, 16'h00A5);
    rd(ADDR_STATUS, v);
    check("tx_busy_status", v & 16'h0008, 16'h0000);
    wait_tx_idle("tx_idle_after_a5");
    check("tx_a5_drained", 16'(exp_tx.size()), 16'd0);
    rd(ADDR_STATUS, v);
    check("status_after_tx", v, 16'h000A);

    // Single RX byte
    exp_rx.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    rd(ADDR_STATUS, v);
    check("rx_status_avail", v, 16'h000B);
    set_addr(ADDR_DATA);
    rd_data_chk("rx_data_3c");
    rd(ADDR_STATUS, v);
    check("rx_status_empty", v, 16'h000A);

    // TX overflow: one byte in flight, eight fill the FIFO, the ninth is dropped
    exp_tx.push_back(8'h11);
    wr(ADDR_DATA, 16'h0011);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_tx.push_back(8'(8'h20 + i));
      cyc(1'b0, 1'b1, 1'b0, 16'(16'h20 + i), v);
    end
    rd(ADDR_STATUS, v);
    check("tx_overflow_set", v, 16'h0020);
    cyc(1'b0, 1'b0, 1'b1, 16'h0, v);
    check("tx_overflow_clear", v, 16'h0000);
    wait_tx_idle("tx_idle_after_burst");
    check("tx_burst_drained", 16'(exp_tx.size()), 16'd0);
    rd(ADDR_STATUS, v);
    check("status_after_burst", v, 16'h000A);

    // RX overrun: nine frames, only eight fit
    for (int i = 0; i < 9; i++) begin
      if (exp_rx.size() < 8) exp_rx.push_back(8'(8'h50 + 7 * i));
      send_frame(8'(8'h50 + 7 * i), 1'b1);
    end
    rd(ADDR_STATUS, v);
    check("rx_overrun_status", v, 16'h000F);
    set_addr(ADDR_DATA);
    for (int i = 0; i < 9; i++) rd_data_chk($sformatf("rx_overrun_data%0d", i));
    rd(ADDR_STATUS, v);
    check("rx_overrun_cleared", v, 16'h000A);

    // Framing error
    send_frame(8'h77, 1'b0);
    rd(ADDR_STATUS, v);
    check("framing_err_status", v, 16'h001A);
    rd(ADDR_STATUS, v);
    check("framing_err_cleared", v, 16'h000A);

    // One-cycle glitch is ignored, and a real frame afterwards is still received
    @(negedge clk);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    rd(ADDR_STATUS, v);
    check("glitch_ignored", v, 16'h000A);
    exp_rx.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    set_addr(ADDR_DATA);
    rd_data_chk("rx_after_glitch");

    // Reset in the middle of a character
    mon_en = 1'b0;
    wr(ADDR_DATA, 16'h0000);
    repeat (12) @(negedge clk);
    check("mid_tx_line_low", {15'd0, txd}, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_mid_tx_txd", {15'd0, txd}, 16'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_tx.delete();
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad = 1'b1;
    end
    check("txd_idle_after_reset", {15'd0, bad}, 16'd0);
    rd(ADDR_STATUS, v);
    check("status_after_reset", v, 16'h000A);
    rd(ADDR_DIV, v);
    check("div_after_reset", v, 16'h0068);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_port.md
Name: serial_port

Overview:
- Bus-attached UART peripheral on the CPU's device path.
- The CPU latches a device address with MI, writes with DI and reads with DO.
- Provides buffered 8N1 transmit and receive, with a status register and a programmable baud divisor.
- Sits directly downstream of the CPU's DI/DO/MI control bits and shares the 16-bit bus.

Parameters:
- FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs (power of two, >=2).
- DIV_RESET, 16'd104, reset value of the baud divisor (clocks per bit).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- bus_in  in  16  bus value driven by the CPU this cycle.
- bus_out  out  16  read data; 16'h0000 whenever DO=0.
- bus_oe  out  1  equals DO; bus tristate enable.
- MI  in  1  latch address: addr <= bus_in[1:0].
- DI  in  1  device write strobe, at address addr.
- DO  in  1  device read strobe, at address addr.
- txd  out  1  serial output, idle high.
- rxd  in  1  serial input, asynchronous to clk.

Behaviour:
- Reset values:
  - addr=0; div=DIV_RESET; both FIFOs empty; all sticky flags=0.
  - txd=1; TX and RX engines IDLE; bus_out=0.
- Register map (addr):
  - 0 DATA: write pushes bus_in[7:0]; read returns {8'h00, RX head}, or 16'h0000 if RX is empty.
  - 1 STATUS: bit0 rx_avail; bit1 tx_not_full; bit2 rx_overrun; bit3 tx_idle (FIFO empty and engine IDLE); bit4 framing_err; bit5 tx_overflow; other bits 0.
  - 2 DIV: read/write 16-bit divisor. Writes of 0 or 1 store 2.
  - 3: reads 0; writes ignored.
- Read data is combinational from addr and state.
- Side effects happen at the clock edge ending the DO cycle:
  - DATA read pops RX (no-op if empty).
  - STATUS read clears bits 2, 4 and 5.
  - A flag set in the same cycle as a STATUS read stays set.
- MI and DI/DO in the same cycle: the access uses the old addr; the new addr takes effect next cycle.
- DATA write with TX full: byte dropped, tx_overflow set.
- FIFO push and pop in the same cycle:
  - Both happen, count unchanged.
  - When full, a pop plus push is accepted.
  - When empty, a pop plus push leaves the byte stored.
- TX engine, states IDLE -> START -> DATA(8) -> STOP -> IDLE:
  - Leaves IDLE the cycle after the FIFO is non-empty, popping one byte.
  - START drives txd=0, DATA drives bits LSB first, STOP drives txd=1.
  - Each state/bit lasts exactly div clocks.
  - Back-to-back bytes: STOP goes straight to START if the FIFO is non-empty (no extra idle bit).
- RX engine, states IDLE -> START -> DATA(8) -> STOP -> IDLE:
  - rxd passes through a 2-flop synchroniser.
  - A falling edge in IDLE enters START.
  - At div/2 clocks, if the line is high again it is a glitch: return to IDLE. Otherwise sample every div clocks thereafter.
  - STOP sample 0: framing_err set, byte discarded.
  - STOP sample 1: byte pushed. If RX is full and not popped that cycle, the byte is discarded and rx_overrun set.
- DIV write mid-character: the current bit finishes with the old count; following bits use the new div.
- Asynchronous reset mid-character:
  - Engines abort immediately, FIFOs empty, txd=1.
  - No partial byte is pushed after release.

Decomposition:
- Shared package holds:
  - Address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_DIV=2.
  - STATUS bit index constants.
  - Engine state encoding: IDLE, START, DATA, STOP.
- One natural sub-module, serial_fifo (width 8, depth FIFO_DEPTH, push/pop/full/empty/head), instantiated twice.
- TX and RX engines stay inline.

Test Plan:
- Reset, MI with bus 1, DO -> bus_out=16'h000A (tx_not_full, tx_idle).
- MI 2, DI 16'd4; MI 0, DI 16'h00A5 -> txd low 4 clocks, then 1,0,1,0,0,1,0,1 (LSB first), each 4 clocks; then high. STATUS bit3 returns to 1 after stop.
- div=4: drive rxd with 0x3C frame -> STATUS=0x000B; DATA read=16'h003C; next STATUS=0x000A.
- div=4, 9 DATA writes back-to-back while engine busy -> tx_overflow set, 8 bytes plus 1 in-flight byte transmitted in order. STATUS read clears bit5.
- Receive 9 frames without reading -> rx_overrun=1; DATA reads return first 8 bytes in order, then 16'h0000.
- Frame with stop bit 0 -> framing_err=1, RX stays empty. 1-clock low glitch on rxd -> no reception. Reset asserted mid-TX -> txd=1 immediately.
